// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory controller.
// One request at a time: IDLE accepts, WAIT counts down the access latency,
// the access happens on the last WAIT edge, and RESP presents a one-cycle
// response. Storage is split into four byte lanes so that a word, a halfword
// or a single byte maps onto per-lane write enables within one word row.

module data_mem_lane #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [VEC_W-1:0] wdata,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] mem [WORDS];

  // byte store; contents survive reset on purpose
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int WORDS     = DEPTH / NUM_LANES;
  localparam int IDX_W     = ADDR_W - 2;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  logic             access;

  logic [1:0]       size_m1;
  logic             bad_f3, bad_align, bad_range, err;
  logic [ADDR_W:0]  last_addr;

  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdata;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_word;
  logic [VEC_W-1:0]                rd_byte;
  logic [15:0]                     rd_half;
  logic [31:0]                     load_data;

  assign req_ready = (state == S_IDLE);
  assign access    = (state == S_WAIT) && (cnt == '0);

  // access legality from the latched request: encoding, alignment, range
  always_comb begin
    size_m1 = 2'd0;
    bad_f3  = 1'b0;
    case (req_q.funct3)
      3'b000, 3'b100: size_m1 = 2'd0;
      3'b001, 3'b101: size_m1 = 2'd1;
      3'b010:         size_m1 = 2'd3;
      default:        bad_f3  = 1'b1;
    endcase
    // unsigned variants only make sense for loads
    if (req_q.we && req_q.funct3[2]) bad_f3 = 1'b1;
    bad_align = ((size_m1 == 2'd1) && req_q.addr[0]) ||
                ((size_m1 == 2'd3) && (req_q.addr[1:0] != 2'b00));
    last_addr = {1'b0, req_q.addr} + (ADDR_W+1)'(size_m1);
    bad_range = (32'(last_addr) >= 32'(DEPTH));
    err       = bad_f3 || bad_align || bad_range;
  end

  // lane enables and store data replicated so each lane picks its own byte
  always_comb begin
    be         = '0;
    lane_wdata = req_q.wdata;
    case (size_m1)
      2'd0: begin
        be         = 4'b0001 << req_q.addr[1:0];
        lane_wdata = {NUM_LANES{req_q.wdata[7:0]}};
      end
      2'd1: begin
        be         = req_q.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_q.wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    lane_we = be & {NUM_LANES{access && req_q.we && !err}};
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lane #(.WORDS(WORDS), .IDX_W(IDX_W), .VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[g]),
      .idx   (req_q.addr[ADDR_W-1:2]),
      .wdata (lane_wdata[g]),
      .rdata (rd_word[g])
    );
  end

  // load extraction and sign/zero extension
  always_comb begin
    rd_byte = rd_word[req_q.addr[1:0]];
    rd_half = req_q.addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
    case (req_q.funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // request FSM: latch, count down, access + register response, pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
          cnt   <= CNT_W'(LATENCY - 1);
          state <= S_WAIT;
        end
        S_WAIT: if (cnt == '0) begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || req_q.we) ? 32'h0 : load_data;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a byte-array reference model.
// Three instances: default (LATENCY 2, 1 KiB) and two 64-byte ones with
// LATENCY 1 and 5. Inputs driven on negedge, outputs sampled on negedge.

module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [2:0][31:0] rsp_rdata;

  int n_vec = 0, n_err = 0;
  int lat_of[3] = '{2, 1, 5};
  int dep_of[3] = '{1024, 64, 64};
  logic [7:0] mdl [3][1024];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(10), .DEPTH(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  data_mem_ctrl #(.ADDR_W(6), .DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr[5:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  data_mem_ctrl #(.ADDR_W(6), .DEPTH(64), .LATENCY(5)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr[5:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // behavioural model of one access; updates the model memory for stores
  task automatic ref_access(int d, bit we, bit [2:0] f3, int a, bit [31:0] wd,
                            output bit e_err, output bit [31:0] e_rd);
    int size;
    bit [31:0] v;
    e_err = 1'b0;
    e_rd  = 32'h0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 1; e_err = 1'b1; end
    endcase
    if (we && (f3 == 3'd4 || f3 == 3'd5)) e_err = 1'b1;
    if (a % size != 0) e_err = 1'b1;
    if (a + size - 1 >= dep_of[d]) e_err = 1'b1;
    if (!e_err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mdl[d][a+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mdl[d][a+i]) << (8*i));
        if (f3 != 3'd4 && f3 != 3'd5 && size < 4 && v[8*size-1])
          v = v | ~((32'h1 << (8*size)) - 32'h1);
        e_rd = v;
      end
    end
  endtask

  // one handshake + response, checked for latency, pulse width and data
  task automatic do_req(int d, bit we, bit [2:0] f3, bit [9:0] a, bit [31:0] wd,
                        output bit [31:0] got_rd, output bit got_err);
    bit e_err;
    bit [31:0] e_rd;
    int j;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid[d] = 1'b1;
    j = 0;
    while (!req_ready[d] && j < 50) begin @(negedge clk); j++; end
    if (j >= 50) chk("ready_timeout", 32'(j), 32'(0));
    @(posedge clk);
    ref_access(d, we, f3, int'(a), wd, e_err, e_rd);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = 10'($urandom); req_wdata = $urandom;
    j = 0;
    while (!rsp_valid[d] && j < 20) begin
      if (req_ready[d]) chk("ready_in_wait", 32'(req_ready[d]), 32'(0));
      @(negedge clk);
      j++;
    end
    chk($sformatf("latency_d%0d", d), 32'(j), 32'(lat_of[d]));
    chk("rsp_err", 32'(rsp_err[d]), 32'(e_err));
    chk("rsp_rdata", rsp_rdata[d], e_rd);
    got_rd = rsp_rdata[d];
    got_err = rsp_err[d];
    @(negedge clk);
    chk("pulse_end", 32'({rsp_valid[d], req_ready[d]}), 32'(2'b01));
    chk("rdata_hold", rsp_rdata[d], e_rd);
  endtask

  task automatic run_t1(int d);
    bit [31:0] r;
    bit e;
    do_req(d, 1, 3'd2, 10'h10, 32'h8001_7F02, r, e);
    chk("t1_sw_err", 32'(e), 0);
    chk("t1_sw_rd", r, 32'h0);
    do_req(d, 0, 3'd2, 10'h10, 0, r, e); chk("t1_lw",  r, 32'h8001_7F02);
    do_req(d, 0, 3'd0, 10'h10, 0, r, e); chk("t1_lb",  r, 32'h0000_0002);
    do_req(d, 0, 3'd0, 10'h13, 0, r, e); chk("t1_lb3", r, 32'hFFFF_FF80);
    do_req(d, 0, 3'd4, 10'h13, 0, r, e); chk("t1_lbu", r, 32'h0000_0080);
    do_req(d, 0, 3'd1, 10'h12, 0, r, e); chk("t1_lh",  r, 32'hFFFF_8001);
    do_req(d, 0, 3'd5, 10'h12, 0, r, e); chk("t1_lhu", r, 32'h0000_8001);
  endtask

  initial begin
    bit [31:0] r;
    bit e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(req_ready[d]), 1);
      chk("reset_valid", 32'(rsp_valid[d]), 0);
      chk("reset_err",   32'(rsp_err[d]), 0);
      chk("reset_rdata", rsp_rdata[d], 0);
    end

    // fill every word so the model is fully known
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < dep_of[d]; w += 4)
        do_req(d, 1, 3'd2, 10'(w), $urandom, r, e);

    run_t1(0);

    // sub-word stores into a known word
    do_req(0, 1, 3'd2, 10'h20, 32'h1122_3344, r, e);
    do_req(0, 1, 3'd0, 10'h21, 32'hAAAA_AA5C, r, e);
    do_req(0, 0, 3'd2, 10'h20, 0, r, e); chk("t2_sb", r, 32'h1122_5C44);
    do_req(0, 1, 3'd1, 10'h22, 32'h0000_BEEF, r, e);
    do_req(0, 0, 3'd2, 10'h20, 0, r, e); chk("t2_sh", r, 32'hBEEF_5C44);

    // error cases leave memory alone
    do_req(0, 0, 3'd2, 10'h21, 0, r, e); chk("t3_lw_mis", {31'h0, e}, 1);
    do_req(0, 1, 3'd1, 10'h23, 32'hFFFF_FFFF, r, e); chk("t3_sh_mis", {31'h0, e}, 1);
    do_req(0, 0, 3'd3, 10'h20, 0, r, e); chk("t3_f3_011", {31'h0, e}, 1);
    do_req(0, 1, 3'd4, 10'h20, 32'h0000_00FF, r, e); chk("t3_sbu", {31'h0, e}, 1);
    do_req(0, 0, 3'd2, 10'(1024-2), 0, r, e); chk("t3_lw_end", {31'h0, e}, 1);
    chk("t3_lw_end_rd", r, 0);
    do_req(0, 0, 3'd2, 10'h20, 0, r, e); chk("t3_nowrite", r, 32'hBEEF_5C44);

    // four requests with req_valid held high throughout
    begin
      bit [2:0] f3s[4] = '{3'd2, 3'd2, 3'd4, 3'd1};
      bit       wes[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      bit [9:0] as[4]  = '{10'h80, 10'h80, 10'h81, 10'h82};
      bit [31:0] wd0 = $urandom;
      bit [31:0] eq_rd[$];
      bit eq_err[$];
      int idx = 0, pulses = 0, last = -1, acc_c = -100;
      bit acc, ee;
      bit [31:0] er;
      @(negedge clk);
      req_we = wes[0]; req_funct3 = f3s[0]; req_addr = as[0]; req_wdata = wd0;
      req_valid[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (rsp_valid[0]) begin
          pulses++;
          if (eq_rd.size() > 0) begin
            chk("t4_rd", rsp_rdata[0], eq_rd.pop_front());
            chk("t4_err", 32'(rsp_err[0]), 32'(eq_err.pop_front()));
          end else chk("t4_extra_rsp", 32'(pulses), 4);
          if (last >= 0) chk("t4_gap", 32'(c - last), 32'(lat_of[0] + 2));
          last = c;
        end
        if (c - acc_c >= 1 && c - acc_c <= lat_of[0] + 1)
          chk("t4_ready_low", 32'(req_ready[0]), 0);
        acc = req_valid[0] && req_ready[0];
        if (acc) begin
          ref_access(0, wes[idx], f3s[idx], int'(as[idx]), wd0, ee, er);
          eq_rd.push_back(er);
          eq_err.push_back(ee);
          acc_c = c;
        end
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
          idx++;
          if (idx < 4) begin
            req_we = wes[idx]; req_funct3 = f3s[idx]; req_addr = as[idx];
          end else req_valid[0] = 1'b0;
        end
      end
      chk("t4_pulses", 32'(pulses), 4);
    end

    // reset while a store is waiting drops it
    do_req(0, 1, 3'd2, 10'h40, 32'h0, r, e);
    @(negedge clk);
    req_we = 1; req_funct3 = 3'd2; req_addr = 10'h40; req_wdata = 32'hDEAD_BEEF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    chk("t5_no_rsp0", 32'(rsp_valid[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_no_rsp1", 32'(rsp_valid[0]), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_ready", 32'(req_ready[0]), 1);
      chk("t5_no_rsp", 32'(rsp_valid[0]), 0);
    end
    do_req(0, 0, 3'd2, 10'h40, 0, r, e); chk("t5_lw", r, 32'h0);

    // scaled latency / small depth
    for (int d = 1; d < 3; d++) begin
      run_t1(d);
      do_req(d, 0, 3'd2, 10'h3C, 0, r, e); chk("t6_lw3c_err", {31'h0, e}, 0);
      do_req(d, 0, 3'd2, 10'h3E, 0, r, e); chk("t6_lw3e_err", {31'h0, e}, 1);
    end

    // random traffic on all instances
    for (int n = 0; n < 300; n++) begin
      int d;
      bit [9:0] a;
      d = (n % 3);
      a = 10'($urandom_range(0, dep_of[d] - 1));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) a = 10'(dep_of[d] - $urandom_range(1, 4));
      do_req(d, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, r, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
